// File: rtl/agc_pkg.sv
// Shared types, constants and arithmetic helpers for the multi-channel AGC accumulator bank.
package agc_pkg;

  localparam int unsigned SQ_OFFSET = 16384;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StLatch
  } agc_state_e;

  localparam logic [1:0] RdSelSq   = 2'd0;
  localparam logic [1:0] RdSelGt   = 2'd1;
  localparam logic [1:0] RdSelLt   = 2'd2;
  localparam logic [1:0] RdSelStat = 2'd3;

  // Saturating add into a 'width'-bit accumulator (width <= 32); returns the clamped sum.
  function automatic logic [31:0] sat_add(input logic [31:0] acc, input logic [31:0] inc,
                                          input int unsigned width);
    logic [32:0] sum;
    logic [32:0] lim;
    sum = {1'b0, acc} + {1'b0, inc};
    lim = (33'd1 << width) - 33'd1;
    return 32'((sum > lim) ? lim : sum);
  endfunction

  // True when the same add would exceed the all-ones value of a 'width'-bit accumulator.
  function automatic logic sat_ovf(input logic [31:0] acc, input logic [31:0] inc,
                                   input int unsigned width);
    logic [32:0] sum;
    logic [32:0] lim;
    sum = {1'b0, acc} + {1'b0, inc};
    lim = (33'd1 << width) - 33'd1;
    return sum > lim;
  endfunction

  function automatic logic [7:0] popcount(input logic [31:0] v);
    logic [7:0] cnt;
    cnt = '0;
    for (int i = 0; i < 32; i++) begin
      cnt = cnt + 8'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/agc_chan_accum.sv
// One channel's square / above-threshold / below-threshold saturating accumulators
// with a sticky overflow flag.
module agc_chan_accum
  import agc_pkg::*;
#(
  parameter int unsigned NSAMP   = 8,
  parameter int unsigned ABITS   = 4,
  parameter int unsigned SQ_BITS = 24,
  parameter int unsigned PR_BITS = 21
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               acc_en_i,
  input  logic               clr_i,
  input  logic [ABITS-1:0]   abs_i,
  input  logic [NSAMP-1:0]   gt_i,
  input  logic [NSAMP-1:0]   lt_i,
  output logic [SQ_BITS-1:0] sq_o,
  output logic [PR_BITS-1:0] gt_o,
  output logic [PR_BITS-1:0] lt_o,
  output logic               ovf_o
);

  logic [SQ_BITS-1:0] sq_q, sq_d;
  logic [PR_BITS-1:0] gt_q, gt_d;
  logic [PR_BITS-1:0] lt_q, lt_d;
  logic               ovf_q;
  logic               ovf_hit;
  logic [2*ABITS-1:0] sq_inc;
  logic [31:0]        gt_inc;
  logic [31:0]        lt_inc;

  assign sq_inc = {{ABITS{1'b0}}, abs_i} * {{ABITS{1'b0}}, abs_i};
  assign gt_inc = 32'(popcount(32'(gt_i)));
  assign lt_inc = 32'(popcount(32'(lt_i)));

  always_comb begin
    sq_d    = SQ_BITS'(sat_add(32'(sq_q), 32'(sq_inc), SQ_BITS));
    gt_d    = PR_BITS'(sat_add(32'(gt_q), gt_inc, PR_BITS));
    lt_d    = PR_BITS'(sat_add(32'(lt_q), lt_inc, PR_BITS));
    ovf_hit = sat_ovf(32'(sq_q), 32'(sq_inc), SQ_BITS) |
              sat_ovf(32'(gt_q), gt_inc, PR_BITS) |
              sat_ovf(32'(lt_q), lt_inc, PR_BITS);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sq_q <= SQ_BITS'(SQ_OFFSET);
      gt_q <= '0;
      lt_q <= '0;
    end else if (start_i) begin
      sq_q <= SQ_BITS'(SQ_OFFSET);
      gt_q <= '0;
      lt_q <= '0;
    end else if (acc_en_i) begin
      sq_q <= sq_d;
      gt_q <= gt_d;
      lt_q <= lt_d;
    end
  end

  // A new saturation event beats a coincident clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ovf_q <= 1'b0;
    end else if (acc_en_i && ovf_hit) begin
      ovf_q <= 1'b1;
    end else if (clr_i) begin
      ovf_q <= 1'b0;
    end
  end

  assign sq_o  = sq_q;
  assign gt_o  = gt_q;
  assign lt_o  = lt_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/agc_accum_bank.sv
// Multi-channel AGC measurement bank: period FSM, per-channel accumulators,
// end-of-period holding registers and a registered read port.
module agc_accum_bank
  import agc_pkg::*;
#(
  parameter int unsigned NCHAN   = 8,
  parameter int unsigned NSAMP   = 8,
  parameter int unsigned ABITS   = 4,
  parameter int unsigned SQ_BITS = 24,
  parameter int unsigned PR_BITS = 21,
  parameter int unsigned PMAX    = 17
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       en_i,
  input  logic                       tick_i,
  input  logic [4:0]                 period_i,
  input  logic [NCHAN*ABITS-1:0]     abs_i,
  input  logic [NCHAN*NSAMP-1:0]     gt_i,
  input  logic [NCHAN*NSAMP-1:0]     lt_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [NCHAN-1:0]           ovf_o,
  output logic                       tick_miss_o,
  input  logic                       clr_i,
  input  logic                       rd_en_i,
  input  logic [$clog2(NCHAN)-1:0]   rd_chan_i,
  input  logic [1:0]                 rd_sel_i,
  output logic [SQ_BITS-1:0]         rd_data_o,
  output logic                       rd_valid_o
);

  localparam int unsigned CntW  = PMAX;
  localparam int unsigned NSlot = 2 ** $clog2(NCHAN);

  agc_state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [CntW:0]   pow2;
  logic [4:0]      per_clamped;
  logic            start;
  logic            acc_en;
  logic            latch;
  logic            done_q;
  logic            tick_miss_q;
  logic            rd_valid_q;
  logic [SQ_BITS-1:0] rd_data_q;
  logic [SQ_BITS-1:0] rd_mux;

  logic [SQ_BITS-1:0] sq_acc    [NCHAN];
  logic [PR_BITS-1:0] gt_acc    [NCHAN];
  logic [PR_BITS-1:0] lt_acc    [NCHAN];
  logic [SQ_BITS-1:0] sq_hold_q [NCHAN];
  logic [PR_BITS-1:0] gt_hold_q [NCHAN];
  logic [PR_BITS-1:0] lt_hold_q [NCHAN];

  logic [SQ_BITS-1:0] sq_slot   [NSlot];
  logic [SQ_BITS-1:0] gt_slot   [NSlot];
  logic [SQ_BITS-1:0] lt_slot   [NSlot];
  logic [SQ_BITS-1:0] st_slot   [NSlot];

  assign per_clamped = (period_i > 5'(PMAX)) ? 5'(PMAX) : period_i;
  assign pow2        = (CntW + 1)'(1) << per_clamped;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    start   = 1'b0;
    acc_en  = 1'b0;
    latch   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (tick_i && en_i) begin
          start   = 1'b1;
          cnt_d   = CntW'(pow2 - (CntW + 1)'(1));
          state_d = StRun;
        end
      end
      StRun: begin
        if (!en_i) begin
          state_d = StIdle;
        end else begin
          acc_en = 1'b1;
          cnt_d  = cnt_q - CntW'(1);
          if (cnt_q == '0) begin
            state_d = StLatch;
          end
        end
      end
      StLatch: begin
        latch   = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= latch;
    end
  end

  // A tick that cannot be honoured is recorded; the set beats a coincident clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tick_miss_q <= 1'b0;
    end else if (tick_i && (state_q != StIdle)) begin
      tick_miss_q <= 1'b1;
    end else if (clr_i) begin
      tick_miss_q <= 1'b0;
    end
  end

  for (genvar c = 0; c < NCHAN; c++) begin : g_chan
    agc_chan_accum #(
      .NSAMP   (NSAMP),
      .ABITS   (ABITS),
      .SQ_BITS (SQ_BITS),
      .PR_BITS (PR_BITS)
    ) u_accum (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .start_i  (start),
      .acc_en_i (acc_en),
      .clr_i    (clr_i),
      .abs_i    (abs_i[c*ABITS +: ABITS]),
      .gt_i     (gt_i[c*NSAMP +: NSAMP]),
      .lt_i     (lt_i[c*NSAMP +: NSAMP]),
      .sq_o     (sq_acc[c]),
      .gt_o     (gt_acc[c]),
      .lt_o     (lt_acc[c]),
      .ovf_o    (ovf_o[c])
    );
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int c = 0; c < NCHAN; c++) begin
        sq_hold_q[c] <= SQ_BITS'(SQ_OFFSET);
        gt_hold_q[c] <= '0;
        lt_hold_q[c] <= '0;
      end
    end else if (latch) begin
      for (int c = 0; c < NCHAN; c++) begin
        sq_hold_q[c] <= sq_acc[c];
        gt_hold_q[c] <= gt_acc[c];
        lt_hold_q[c] <= lt_acc[c];
      end
    end
  end

  // Pad the channel index space to a power of two so out-of-range channels read as zero.
  for (genvar s = 0; s < NSlot; s++) begin : g_slot
    if (s < NCHAN) begin : g_used
      assign sq_slot[s] = sq_hold_q[s];
      assign gt_slot[s] = SQ_BITS'(gt_hold_q[s]);
      assign lt_slot[s] = SQ_BITS'(lt_hold_q[s]);
      assign st_slot[s] = SQ_BITS'(ovf_o[s]);
    end else begin : g_pad
      assign sq_slot[s] = '0;
      assign gt_slot[s] = '0;
      assign lt_slot[s] = '0;
      assign st_slot[s] = '0;
    end
  end

  always_comb begin
    rd_mux = '0;
    unique case (rd_sel_i)
      RdSelSq:   rd_mux = sq_slot[rd_chan_i];
      RdSelGt:   rd_mux = gt_slot[rd_chan_i];
      RdSelLt:   rd_mux = lt_slot[rd_chan_i];
      RdSelStat: rd_mux = st_slot[rd_chan_i];
      default:   rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_en_i;
      if (rd_en_i) begin
        rd_data_q <= rd_mux;
      end
    end
  end

  assign busy_o      = (state_q != StIdle);
  assign done_o      = done_q;
  assign tick_miss_o = tick_miss_q;
  assign rd_data_o   = rd_data_q;
  assign rd_valid_o  = rd_valid_q;

endmodule

// File: tb/tb_agc_accum_bank.sv
// Directed self-checking bench for agc_accum_bank; read results are checked through a
// scoreboard queue filled when a read is issued and drained when rd_valid_o returns.
module tb_agc_accum_bank;

  localparam int unsigned NCHAN   = 6;
  localparam int unsigned NSAMP   = 8;
  localparam int unsigned ABITS   = 4;
  localparam int unsigned SQ_BITS = 18;
  localparam int unsigned PR_BITS = 16;
  localparam int unsigned PMAX    = 12;
  localparam int unsigned CW      = $clog2(NCHAN);

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic                     en = 1'b1;
  logic                     tick = 1'b0;
  logic [4:0]               period = '0;
  logic [NCHAN*ABITS-1:0]   abs_v = '0;
  logic [NCHAN*NSAMP-1:0]   gt_v = '0;
  logic [NCHAN*NSAMP-1:0]   lt_v = '0;
  logic                     busy;
  logic                     done;
  logic [NCHAN-1:0]         ovf;
  logic                     tick_miss;
  logic                     clr = 1'b0;
  logic                     rd_en = 1'b0;
  logic [CW-1:0]            rd_chan = '0;
  logic [1:0]               rd_sel = '0;
  logic [SQ_BITS-1:0]       rd_data;
  logic                     rd_valid;

  int n_chk  = 0;
  int n_pass = 0;
  int done_cnt = 0;
  logic [31:0] exp_q [$];
  string       tag_q [$];

  agc_accum_bank #(
    .NCHAN   (NCHAN),
    .NSAMP   (NSAMP),
    .ABITS   (ABITS),
    .SQ_BITS (SQ_BITS),
    .PR_BITS (PR_BITS),
    .PMAX    (PMAX)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .en_i        (en),
    .tick_i      (tick),
    .period_i    (period),
    .abs_i       (abs_v),
    .gt_i        (gt_v),
    .lt_i        (lt_v),
    .busy_o      (busy),
    .done_o      (done),
    .ovf_o       (ovf),
    .tick_miss_o (tick_miss),
    .clr_i       (clr),
    .rd_en_i     (rd_en),
    .rd_chan_i   (rd_chan),
    .rd_sel_i    (rd_sel),
    .rd_data_o   (rd_data),
    .rd_valid_o  (rd_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
  endtask

  // Issue a read; expected value goes to the scoreboard, compared when rd_valid_o shows up.
  task automatic issue_read(input int ch, input int sel, input logic [31:0] expv,
                            input string tag);
    rd_en   = 1'b1;
    rd_chan = CW'(ch);
    rd_sel  = 2'(sel);
    exp_q.push_back(expv);
    tag_q.push_back(tag);
  endtask

  task automatic collect_read();
    check("rd_valid", 32'(rd_valid), 32'd1);
    if (rd_valid && exp_q.size() > 0) begin
      check(tag_q.pop_front(), 32'(rd_data), exp_q.pop_front());
    end
  endtask

  task automatic do_read(input int ch, input int sel, input logic [31:0] expv,
                         input string tag);
    issue_read(ch, sel, expv, tag);
    step();
    rd_en = 1'b0;
    collect_read();
  endtask

  // Start a measurement and count clocks from the tick edge until done_o (bounded).
  task automatic measure(input int per, input int miss_at, output int lat);
    period = 5'(per);
    tick   = 1'b1;
    step();
    tick = 1'b0;
    lat  = 0;
    while (!done && lat < 5000) begin
      tick = (miss_at != 0) && (lat + 1 == miss_at);
      step();
      lat++;
    end
    tick = 1'b0;
  endtask

  initial begin
    int lat;
    int d0;

    // Reset state
    rst = 1'b1;
    step();
    step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_miss", 32'(tick_miss), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    rst = 1'b0;
    step();
    do_read(0, 0, 32'd16384, "rst_hold_sq");
    do_read(2, 1, 32'd0, "rst_hold_gt");

    // Basic period 4 measurement
    abs_v = {NCHAN{4'd3}};
    gt_v  = '1;
    lt_v  = '0;
    measure(4, 0, lat);
    check("p4_latency", 32'(lat), 32'd17);
    check("p4_busy_after_done", 32'(busy), 32'd0);
    step();
    check("p4_done_pulse", 32'(done), 32'd0);
    do_read(0, 0, 32'd16528, "p4_sq_ch0");
    check("rd_valid_pulse", 32'(rd_valid & 1'b1), 32'd1);
    step();
    check("rd_valid_drop", 32'(rd_valid), 32'd0);
    do_read(5, 1, 32'd128, "p4_gt_ch5");
    do_read(5, 2, 32'd0, "p4_lt_ch5");
    check("p4_ovf", 32'(ovf), 32'd0);

    // Tick during RUN is a miss and leaves the period alone
    abs_v = {NCHAN{4'd2}};
    measure(4, 5, lat);
    check("miss_latency", 32'(lat), 32'd17);
    check("miss_flag", 32'(tick_miss), 32'd1);
    do_read(1, 0, 32'd16448, "miss_sq_ch1");
    do_read(1, 1, 32'd128, "miss_gt_ch1");
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("miss_clr", 32'(tick_miss), 32'd0);

    // Abort mid-RUN: no done, holding regs unchanged
    abs_v  = {NCHAN{4'd5}};
    period = 5'd4;
    tick   = 1'b1;
    step();
    tick = 1'b0;
    for (int i = 0; i < 5; i++) step();
    d0 = done_cnt;
    en = 1'b0;
    step();
    check("abort_busy", 32'(busy), 32'd0);
    en = 1'b1;
    for (int i = 0; i < 20; i++) step();
    check("abort_no_done", 32'(done_cnt), 32'(d0));
    do_read(0, 0, 32'd16448, "abort_hold_sq");

    // Read in the LATCH cycle returns the pre-latch value
    abs_v = {NCHAN{4'd1}};
    gt_v  = '0;
    lt_v  = '1;
    measure(2, 0, lat);
    check("p2_latency", 32'(lat), 32'd5);
    do_read(3, 2, 32'd32, "p2_lt_ch3");
    period = 5'd3;
    tick   = 1'b1;
    step();
    tick = 1'b0;
    for (int i = 0; i < 8; i++) step();
    check("latch_busy", 32'(busy), 32'd1);
    issue_read(3, 2, 32'd32, "latch_old_lt");
    step();
    rd_en = 1'b0;
    check("latch_done", 32'(done), 32'd1);
    collect_read();
    do_read(3, 2, 32'd64, "latch_new_lt");
    do_read(3, 0, 32'd16392, "latch_new_sq");
    do_read(7, 0, 32'd0, "oob_chan");

    // Square saturation on channel 0 only
    abs_v = '0;
    abs_v[3:0] = 4'd15;
    gt_v = '0;
    lt_v = '0;
    measure(12, 0, lat);
    check("sat_latency", 32'(lat), 32'd4097);
    check("sat_ovf", 32'(ovf), 32'd1);
    do_read(0, 0, 32'd262143, "sat_sq_ch0");
    do_read(1, 0, 32'd16384, "sat_sq_ch1");
    do_read(0, 3, 32'd1, "sat_stat_ch0");
    do_read(1, 3, 32'd0, "sat_stat_ch1");
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("sat_clr", 32'(ovf), 32'd0);

    // Period above PMAX clamps to PMAX
    abs_v = {NCHAN{4'd1}};
    gt_v  = '1;
    measure(31, 0, lat);
    check("clamp_latency", 32'(lat), 32'd4097);
    do_read(2, 0, 32'd20480, "clamp_sq_ch2");
    do_read(4, 1, 32'd32768, "clamp_gt_ch4");

    // Reset in the middle of RUN
    abs_v = {NCHAN{4'd3}};
    period = 5'd4;
    tick   = 1'b1;
    step();
    tick = 1'b0;
    for (int i = 0; i < 3; i++) step();
    tick = 1'b1;
    step();
    tick = 1'b0;
    check("pre_rst_miss", 32'(tick_miss), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_miss", 32'(tick_miss), 32'd0);
    check("mid_rst_rd_data", 32'(rd_data), 32'd0);
    check("mid_rst_rd_valid", 32'(rd_valid), 32'd0);
    step();
    rst = 1'b0;
    step();
    do_read(2, 0, 32'd16384, "post_rst_sq_ch2");
    do_read(4, 1, 32'd0, "post_rst_gt_ch4");

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
